// File: rtl/adder_feed.sv
// Operand sequencer feeding an external three-operand 32-bit adder and registering its {cout,result}.
// Optional feature: define ADDER_FEED_OVF_CNT_EN to build the saturating carry-out counter on ovf_count.
module adder_feed (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        in_cin,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [31:0] operand3,
    output logic        cin,
    input  logic [31:0] result,
    input  logic        cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_cout,
    output logic [15:0] ovf_count
);

    typedef enum logic [2:0] {
        LOAD0,
        LOAD1,
        LOAD2,
        EXEC,
        HOLD
    } state_t;

    state_t state, state_next;
    logic   accept;

    always_comb begin
        in_ready   = 1'b0;
        state_next = state;
        case (state)
            LOAD0, LOAD1, LOAD2: in_ready = resetn;
            default:             in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
        case (state)
            LOAD0:   if (accept) state_next = in_last ? EXEC : LOAD1;
            LOAD1:   if (accept) state_next = in_last ? EXEC : LOAD2;
            LOAD2:   if (accept) state_next = EXEC;
            EXEC:    state_next = HOLD;
            HOLD:    if (out_ready) state_next = LOAD0;
            default: state_next = LOAD0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= LOAD0;
        else         state <= state_next;
    end

    // Operand capture; operands stay frozen through EXEC/HOLD because nothing is accepted there.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            operand1  <= '0;
            operand2  <= '0;
            operand3  <= '0;
            cin       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
        end else begin
            if (accept) begin
                case (state)
                    LOAD0: begin
                        operand1 <= in_data;
                        operand2 <= '0;
                        operand3 <= '0;
                        cin      <= in_last ? in_cin : 1'b0;
                    end
                    LOAD1: begin
                        operand2 <= in_data;
                        if (in_last) cin <= in_cin;
                    end
                    LOAD2: begin
                        operand3 <= in_data;
                        cin      <= in_cin;
                    end
                    default: ;
                endcase
            end
            // Result capture: the adder has had the whole EXEC cycle to settle.
            if (state == EXEC) begin
                out_sum   <= result;
                out_cout  <= cout;
                out_valid <= 1'b1;
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ADDER_FEED_OVF_CNT_EN
    logic [15:0] ovf_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn)                   ovf_q <= '0;
        else if (state == EXEC && cout) ovf_q <= sat_inc(ovf_q);
    end

    assign ovf_count = ovf_q;
`else
    assign ovf_count = 16'h0000;
`endif

endmodule
